// File: rtl/mem_ctrl_pkg.sv
// Shared types for the memory-side controllers: access size, arbiter states and port owner.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10
    } size_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_LS
    } owner_t;

    // The reserved encoding 2'b11 behaves as a word access.
    function automatic size_t norm_size(input logic [1:0] raw);
        return (raw == 2'b11) ? SIZE_WORD : size_t'(raw);
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selector between the IF and LS requesters.
// MEM_ARB_ROUND_ROBIN_EN selects alternating priority on collisions; otherwise LS always wins.
module mem_arb_pick
    import mem_ctrl_pkg::*;
(
    input  logic   if_req,
    input  logic   ls_req,
    input  owner_t last_grant,
    output owner_t grant
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_comb begin
        grant = OWN_LS;
        if (if_req && ls_req) begin
            grant = (last_grant == OWN_LS) ? OWN_IF : OWN_LS;
        end else if (if_req) begin
            grant = OWN_IF;
        end
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        grant = OWN_LS;
        if (if_req && !ls_req) begin
            grant = OWN_IF;
        end
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port (IF/LS) arbiter in front of the single-port byte memory with a registered handshake.
// Build option: MEM_ARB_ROUND_ROBIN_EN (evaluated inside mem_arb_pick).
module mem_port_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetn_i,

    input  logic                  if_req_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    output logic                  if_ack_o,
    output logic [DATA_WIDTH-1:0] if_rdata_o,

    input  logic                  ls_req_i,
    input  logic                  ls_we_i,
    input  logic [1:0]            ls_size_i,
    input  logic [ADDR_WIDTH-1:0] ls_addr_i,
    input  logic [DATA_WIDTH-1:0] ls_wdata_i,
    output logic                  ls_ack_o,
    output logic [DATA_WIDTH-1:0] ls_rdata_o,

    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    output logic                  mem_write_o,
    output logic [1:0]            mem_write_size_o,
    output logic                  mem_valid_o,
    input  logic                  mem_valid_i
);

    arb_state_t            state_q, state_d;
    owner_t                owner_q;
    owner_t                last_grant_q;
    owner_t                grant;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_q;
    size_t                 size_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] if_rdata_q;
    logic [DATA_WIDTH-1:0] ls_rdata_q;
    logic                  any_req;
    logic                  start_access;
    logic                  mem_done;

    assign any_req      = if_req_i | ls_req_i;
    assign start_access = (state_q == IDLE) && any_req;
    assign mem_done     = (state_q == ACCESS) && mem_valid_i;

    // last_grant only influences the pick in the round-robin build; otherwise it is dead logic.
    mem_arb_pick u_pick (
        .if_req     (if_req_i),
        .ls_req     (ls_req_i),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req)     state_d = ACCESS;
            ACCESS:  if (mem_valid_i) state_d = RESP;
            RESP:                     state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn_i) begin
            state_q      <= IDLE;
            owner_q      <= OWN_IF;
            last_grant_q <= OWN_IF;
            addr_q       <= '0;
            we_q         <= 1'b0;
            size_q       <= SIZE_BYTE;
            wdata_q      <= '0;
            if_rdata_q   <= '0;
            ls_rdata_q   <= '0;
        end else begin
            state_q <= state_d;
            if (start_access) begin
                owner_q      <= grant;
                last_grant_q <= grant;
                if (grant == OWN_LS) begin
                    addr_q  <= ls_addr_i;
                    we_q    <= ls_we_i;
                    size_q  <= norm_size(ls_size_i);
                    wdata_q <= ls_wdata_i;
                end else begin
                    addr_q  <= if_addr_i;
                    we_q    <= 1'b0;
                    size_q  <= SIZE_WORD;
                    wdata_q <= '0;
                end
            end
            // Only reads land in the owner's rdata register; the other port keeps its last value.
            if (mem_done && !we_q) begin
                if (owner_q == OWN_IF) begin
                    if_rdata_q <= mem_data_i;
                end else begin
                    ls_rdata_q <= mem_data_i;
                end
            end
        end
    end

    assign mem_valid_o      = (state_q == ACCESS);
    assign mem_addr_o       = addr_q;
    assign mem_write_o      = we_q;
    assign mem_write_size_o = size_q;
    assign mem_data_o       = wdata_q;

    assign if_ack_o   = (state_q == RESP) && (owner_q == OWN_IF);
    assign ls_ack_o   = (state_q == RESP) && (owner_q == OWN_LS);
    assign if_rdata_o = if_rdata_q;
    assign ls_rdata_o = ls_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized request mixes
// against a transaction-level model of grant order, latency and returned data.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        resetn_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_ack_o;
    logic [31:0] if_rdata_o;
    logic        ls_req_i;
    logic        ls_we_i;
    logic [1:0]  ls_size_i;
    logic [31:0] ls_addr_i;
    logic [31:0] ls_wdata_i;
    logic        ls_ack_o;
    logic [31:0] ls_rdata_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic [31:0] mem_data_i;
    logic        mem_write_o;
    logic [1:0]  mem_write_size_o;
    logic        mem_valid_o;
    logic        mem_valid_i;

    int test_count = 0;
    int fail_count = 0;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR_ENABLED = 1'b1;
`else
    localparam bit RR_ENABLED = 1'b0;
`endif

    logic [31:0] mem_words [16];
    int          acc_cycles = 0;
    int          wait_cfg   = 0;

    logic [31:0] model_if_rdata;
    logic [31:0] model_ls_rdata;
    bit          model_last_ls;

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk              (clk),
        .resetn_i         (resetn_i),
        .if_req_i         (if_req_i),
        .if_addr_i        (if_addr_i),
        .if_ack_o         (if_ack_o),
        .if_rdata_o       (if_rdata_o),
        .ls_req_i         (ls_req_i),
        .ls_we_i          (ls_we_i),
        .ls_size_i        (ls_size_i),
        .ls_addr_i        (ls_addr_i),
        .ls_wdata_i       (ls_wdata_i),
        .ls_ack_o         (ls_ack_o),
        .ls_rdata_o       (ls_rdata_o),
        .mem_addr_o       (mem_addr_o),
        .mem_data_o       (mem_data_o),
        .mem_data_i       (mem_data_i),
        .mem_write_o      (mem_write_o),
        .mem_write_size_o (mem_write_size_o),
        .mem_valid_o      (mem_valid_o),
        .mem_valid_i      (mem_valid_i)
    );

    always #5 clk = ~clk;

    // Memory stand-in: combinational read, completes after wait_cfg stalled cycles.
    assign mem_valid_i = mem_valid_o && (acc_cycles >= wait_cfg);
    assign mem_data_i  = mem_words[mem_addr_o[5:2]];

    always @(posedge clk) begin
        if (mem_valid_o) acc_cycles <= acc_cycles + 1;
        else             acc_cycles <= 0;
    end

    always @(posedge clk) begin
        if (!resetn_i) begin
            for (int i = 0; i < 16; i++) begin
                mem_words[i] <= (i == 0) ? 32'h01000093 : (32'hC0DE_0000 | 32'(i));
            end
        end else if (mem_valid_o && mem_valid_i && mem_write_o) begin
            case (mem_write_size_o)
                2'b00:   mem_words[mem_addr_o[5:2]][7:0]  <= mem_data_o[7:0];
                2'b01:   mem_words[mem_addr_o[5:2]][15:0] <= mem_data_o[15:0];
                default: mem_words[mem_addr_o[5:2]]       <= mem_data_o;
            endcase
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        test_count++;
        assert (obs === exp) else begin
            fail_count++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issues the requested accesses from IDLE and follows every one of them to its ack.
    task automatic applyStimulus(input bit do_if, input logic [31:0] ia,
                                 input bit do_ls, input bit we, input logic [1:0] sz,
                                 input logic [31:0] la, input logic [31:0] wd,
                                 input int wait_n, input bit scramble);
        bit          pend_if;
        bit          pend_ls;
        bit          serve_ls;
        logic [31:0] exp_addr;
        logic [31:0] exp_rd;
        logic [1:0]  exp_size;
        bit          exp_we;
        wait_cfg   = wait_n;
        if_req_i   = do_if;
        if_addr_i  = ia;
        ls_req_i   = do_ls;
        ls_we_i    = we;
        ls_size_i  = sz;
        ls_addr_i  = la;
        ls_wdata_i = wd;
        pend_if    = do_if;
        pend_ls    = do_ls;
        while (pend_if || pend_ls) begin
            if (pend_if && pend_ls) serve_ls = RR_ENABLED ? !model_last_ls : 1'b1;
            else                    serve_ls = pend_ls;
            model_last_ls = serve_ls;
            exp_addr = serve_ls ? la : ia;
            exp_we   = serve_ls ? we : 1'b0;
            exp_size = serve_ls ? ((sz == 2'b11) ? 2'b10 : sz) : 2'b10;
            exp_rd   = mem_words[exp_addr[5:2]];

            tick();
            checkOutput("access_valid", 64'(mem_valid_o), 64'(1'b1));
            checkOutput("access_addr", 64'(mem_addr_o), 64'(exp_addr));
            checkOutput("access_write", 64'(mem_write_o), 64'(exp_we));
            checkOutput("access_size", 64'(mem_write_size_o), 64'(exp_size));
            if (exp_we) checkOutput("access_wdata", 64'(mem_data_o), 64'(wd));
            checkOutput("access_acks", 64'({if_ack_o, ls_ack_o}), 64'(2'b00));

            for (int k = 0; k < wait_n; k++) begin
                if (scramble && serve_ls) ls_addr_i = $urandom;
                tick();
                checkOutput("wait_valid", 64'(mem_valid_o), 64'(1'b1));
                checkOutput("wait_addr", 64'(mem_addr_o), 64'(exp_addr));
                checkOutput("wait_acks", 64'({if_ack_o, ls_ack_o}), 64'(2'b00));
            end

            tick();
            checkOutput("resp_valid", 64'(mem_valid_o), 64'(1'b0));
            checkOutput("resp_acks", 64'({if_ack_o, ls_ack_o}), 64'(serve_ls ? 2'b01 : 2'b10));
            if (serve_ls) begin
                if (!we) model_ls_rdata = exp_rd;
                pend_ls  = 1'b0;
                ls_req_i = 1'b0;
            end else begin
                model_if_rdata = exp_rd;
                pend_if  = 1'b0;
                if_req_i = 1'b0;
            end
            checkOutput("resp_if_rdata", 64'(if_rdata_o), 64'(model_if_rdata));
            checkOutput("resp_ls_rdata", 64'(ls_rdata_o), 64'(model_ls_rdata));

            tick();
            checkOutput("idle_valid", 64'(mem_valid_o), 64'(1'b0));
            checkOutput("idle_acks", 64'({if_ack_o, ls_ack_o}), 64'(2'b00));
        end
    endtask

    initial begin
        bit do_if;
        bit do_ls;

        resetn_i   = 1'b0;
        if_req_i   = 1'b0;
        if_addr_i  = '0;
        ls_req_i   = 1'b0;
        ls_we_i    = 1'b0;
        ls_size_i  = 2'b00;
        ls_addr_i  = '0;
        ls_wdata_i = '0;
        model_if_rdata = '0;
        model_ls_rdata = '0;
        model_last_ls  = 1'b0;
        tick();
        tick();
        checkOutput("reset_valid", 64'(mem_valid_o), 64'(1'b0));
        checkOutput("reset_acks", 64'({if_ack_o, ls_ack_o}), 64'(2'b00));
        checkOutput("reset_bus", 64'({mem_write_o, mem_write_size_o, mem_addr_o}), 64'(0));
        checkOutput("reset_wdata", 64'(mem_data_o), 64'(0));
        checkOutput("reset_rdata", {if_rdata_o, ls_rdata_o}, 64'(0));
        resetn_i = 1'b1;
        tick();

        // IF boot fetch of the first instruction word.
        applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 2'b10, 32'h0, 32'h0, 0, 1'b0);
        checkOutput("if_boot_word", 64'(if_rdata_o), 64'(32'h01000093));

        // LS word write followed by a read-back of the same location.
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 2'b10, 32'h18, 32'hDEADBEEF, 0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 2'b10, 32'h18, 32'h0, 0, 1'b0);
        checkOutput("ls_readback", 64'(ls_rdata_o), 64'(32'hDEADBEEF));

        // Colliding requests.
        applyStimulus(1'b1, 32'h4, 1'b1, 1'b0, 2'b10, 32'h8, 32'h0, 0, 1'b0);

        // Slow memory while the LS address wanders.
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 2'b10, 32'h10, 32'h0, 4, 1'b1);

        // Byte write.
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 2'b00, 32'h1C, 32'h000000AA, 0, 1'b0);

        // Reset while the memory is still stalling.
        wait_cfg  = 6;
        if_req_i  = 1'b1;
        if_addr_i = 32'h20;
        tick();
        tick();
        checkOutput("midreset_busy", 64'(mem_valid_o), 64'(1'b1));
        resetn_i = 1'b0;
        if_req_i = 1'b0;
        tick();
        checkOutput("midreset_valid", 64'(mem_valid_o), 64'(1'b0));
        checkOutput("midreset_acks", 64'({if_ack_o, ls_ack_o}), 64'(2'b00));
        checkOutput("midreset_rdata", {if_rdata_o, ls_rdata_o}, 64'(0));
        model_if_rdata = '0;
        model_ls_rdata = '0;
        model_last_ls  = 1'b0;
        resetn_i = 1'b1;
        tick();
        checkOutput("postreset_acks", 64'({if_ack_o, ls_ack_o}), 64'(2'b00));
        applyStimulus(1'b1, 32'h4, 1'b0, 1'b0, 2'b10, 32'h0, 32'h0, 0, 1'b0);

        // Randomized request mixes.
        for (int n = 0; n < 40; n++) begin
            do_if = 1'($urandom_range(0, 1));
            do_ls = 1'($urandom_range(0, 1));
            if (!do_if && !do_ls) do_if = 1'b1;
            applyStimulus(do_if, $urandom, do_ls, 1'($urandom_range(0, 1)),
                          2'($urandom_range(0, 2)), $urandom, $urandom,
                          int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
